cnn_load_ctrl: RTL and testbench
================================

Name: cnn_load_ctrl

Overview:
Avalon-MM slave sequencer sitting between the HPS bus and the CNN byte RAM/engine. It loads the parameter bytes, then the image bytes, from a single DATA register into consecutive RAM addresses, then pulses the engine start. It waits for engine completion with a timeout and latches the 8-bit result for software readback. Status is exposed through a register and an IRQ.

Parameters:
ADDR_W, 8, RAM byte-address width; requires N_PARAM+N_IMG <= 2**ADDR_W
N_PARAM, 32, parameter bytes loaded first, at RAM addresses 0..N_PARAM-1
N_IMG, 64, image bytes loaded next, at addresses N_PARAM..N_PARAM+N_IMG-1
TIMEOUT, 4096, maximum RUN cycles before the error abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  2  register select: 0 CTRL/STATUS, 1 DATA, 2 RESULT, 3 COUNT
writedata  in  8  Avalon write data
readdata  out  8  Avalon read data; readLatency 1
irq  out  1  level interrupt, equal to done|err
ram_we  out  1  RAM byte write enable
ram_addr  out  ADDR_W  RAM write address
ram_wdata  out  8  RAM write data
eng_start  out  1  one-cycle engine start pulse
eng_done  in  1  engine completion pulse
eng_result  in  8  engine result, valid while eng_done=1

Behaviour:
- One clock domain, clk. reset is synchronous and active-high.
- On reset: state=IDLE, ptr=0, result=0, err=0, done=0, readdata=0, ram_we=0, ram_addr=0, ram_wdata=0, eng_start=0, irq=0.
- Accesses count only when chipselect=1. readdata is registered and appears the cycle after read. Reads of unmapped bits return 0.
- CTRL write: bit0=start_load, bit1=abort. If both are set, abort wins.
- STATUS read (addr 0) = {4'b0, err, done, running, loading}.
- RESULT read (addr 2) = the latched result.
- COUNT read (addr 3) = ptr[7:0].
- Any-state abort: go to IDLE, ptr=0, done=0, result unchanged, no eng_start. An eng_done arriving in any state other than RUN is ignored.
- IDLE:
  - start_load -> LOAD; ptr=0, err=0, done=0.
  - A DATA write here sets err=1 and is dropped.
- LOAD (loading=1):
  - Each DATA write registers ram_we=1, ram_addr=ptr, ram_wdata=writedata for exactly the next cycle, then ptr++. One byte per cycle is accepted, back-to-back.
  - The write that makes ptr==N_PARAM+N_IMG moves to START on the same edge.
  - start_load here restarts: ptr=0, stay in LOAD.
- START: eng_start=1 for exactly one cycle -> RUN, timer=0.
- RUN (running=1):
  - eng_done=1 -> result<=eng_result, done=1 -> DONE.
  - Timer counts each cycle. When timer==TIMEOUT-1 with no eng_done: err=1 -> IDLE.
  - If eng_done arrives on the timeout cycle, done wins.
  - A DATA write sets err=1 and is dropped.
- DONE (done=1):
  - A RESULT read returns the result and clears done -> IDLE.
  - start_load -> LOAD (done cleared).
  - A DATA write sets err=1.
- irq is registered from done|err and has 1-cycle latency.
- err is cleared only by start_load or reset.
- Reset mid-LOAD or mid-RUN returns all state to reset values. No RAM write is issued on the reset cycle.

Test Plan:
- Reset, then read STATUS -> readdata=0x00 one cycle later; irq=0; all RAM and engine outputs 0.
- CTRL=0x01, then 96 back-to-back DATA writes of values i=0..95 -> ram_we pulses at addresses 0..95 with data i. One eng_start pulse follows the last write by 2 cycles. STATUS=0x02 during RUN.
- In RUN, drive eng_done with eng_result=0xA7 -> STATUS=0x04, irq=1 next cycle, RESULT read=0xA7. After that read, STATUS=0x00 and irq=0.
- Load 96 bytes, hold eng_done=0 -> exactly TIMEOUT cycles after eng_start, STATUS=0x08 and irq=1. A following CTRL=0x01 clears err and gives STATUS=0x01.
- CTRL=0x01, 10 DATA writes, then CTRL=0x03 -> state IDLE, COUNT=0, no eng_start. A DATA write now sets STATUS=0x08 with no ram_we.
- Assert reset after the 50th DATA write -> all outputs 0, COUNT=0. A reload of 96 bytes then completes normally.

Source files
------------

// File: rtl/cnn_load_ctrl.sv
// Avalon-MM sequencer: streams parameter then image bytes into the CNN RAM,
// starts the engine, waits for completion with a timeout and latches the result.
module cnn_load_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int N_PARAM = 32,
    parameter int N_IMG   = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [1:0]        address,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic              irq,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic [7:0]        eng_result
);

    localparam int TOTAL = N_PARAM + N_IMG;
    // ptr must be able to hold TOTAL itself and always expose 8 COUNT bits
    localparam int PTR_W = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [TMR_W-1:0] timer;
    logic [7:0]       result;
    logic             err;
    logic             done;

    logic       wr_ctrl;
    logic       wr_data;
    logic       rd_result;
    logic       start_load;
    logic       abort;
    logic [7:0] status;

    always_comb begin
        wr_ctrl    = chipselect && write && (address == 2'd0);
        wr_data    = chipselect && write && (address == 2'd1);
        rd_result  = chipselect && read  && (address == 2'd2);
        abort      = wr_ctrl && writedata[1];
        start_load = wr_ctrl && writedata[0] && !writedata[1];
        status     = {4'b0000, err, done, (state == S_RUN), (state == S_LOAD)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            timer     <= '0;
            result    <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            readdata  <= '0;
            irq       <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            eng_start <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            eng_start <= 1'b0;
            irq       <= done | err;

            if (chipselect && read) begin
                case (address)
                    2'd0: readdata <= status;
                    2'd1: readdata <= '0;
                    2'd2: readdata <= result;
                    2'd3: readdata <= ptr[7:0];
                endcase
            end

            if (abort) begin
                state <= S_IDLE;
                ptr   <= '0;
                done  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_load) begin
                            state <= S_LOAD;
                            ptr   <= '0;
                            err   <= 1'b0;
                            done  <= 1'b0;
                        end else if (wr_data) begin
                            err <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (start_load) begin
                            ptr <= '0;
                            err <= 1'b0;
                        end else if (wr_data) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= ptr[ADDR_W-1:0];
                            ram_wdata <= writedata;
                            ptr       <= ptr + PTR_W'(1);
                            if (ptr == PTR_W'(TOTAL - 1))
                                state <= S_START;
                        end
                    end
                    S_START: begin
                        eng_start <= 1'b1;
                        timer     <= '0;
                        state     <= S_RUN;
                        if (wr_data)
                            err <= 1'b1;
                    end
                    S_RUN: begin
                        // completion takes priority over a coincident timeout
                        if (eng_done) begin
                            result <= eng_result;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                        if (wr_data)
                            err <= 1'b1;
                    end
                    S_DONE: begin
                        if (start_load) begin
                            state <= S_LOAD;
                            ptr   <= '0;
                            err   <= 1'b0;
                            done  <= 1'b0;
                        end else if (rd_result) begin
                            done  <= 1'b0;
                            state <= S_IDLE;
                        end else if (wr_data) begin
                            err <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_load_ctrl.sv
// Self-checking bench for cnn_load_ctrl: vector table, directed corner
// sequences and randomized load/run scenarios against a byte-level model.
module tb_cnn_load_ctrl;

    localparam int TO    = 64;
    localparam int TOTAL = 96;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chipselect = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [1:0] address = '0;
    logic [7:0] writedata = '0;
    logic [7:0] readdata;
    logic       irq;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       eng_start;
    logic       eng_done = 1'b0;
    logic [7:0] eng_result = '0;

    cnn_load_ctrl #(.ADDR_W(8), .N_PARAM(32), .N_IMG(64), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .irq(irq), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .eng_start(eng_start), .eng_done(eng_done),
        .eng_result(eng_result)
    );

    always #5 clk = ~clk;

    // RAM / engine observer
    int         cyc = 0;
    int         we_cnt = 0;
    int         last_we_cyc = 0;
    int         start_cnt = 0;
    int         start_cyc = 0;
    logic [7:0] mem [256];

    always @(negedge clk) begin
        cyc++;
        if (ram_we) begin
            mem[ram_addr] = ram_wdata;
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (eng_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        v = readdata;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string name);
        logic [7:0] v;
        rd(a, v);
        chk(name, v, exp);
    endtask

    task automatic pulse_done(input logic [7:0] r);
        eng_done = 1'b1; eng_result = r;
        tick();
        eng_done = 1'b0; eng_result = '0;
    endtask

    task automatic wait_start(input int base, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (start_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [7:0] exp_bytes [TOTAL];

    task automatic full_load();
        wr(2'd0, 8'h01);
        for (int i = 0; i < TOTAL; i++) wr(2'd1, exp_bytes[i]);
    endtask

    task automatic check_mem(input int n, input string name);
        int bad = 0;
        for (int i = 0; i < n; i++) if (mem[i] !== exp_bytes[i]) bad++;
        chk(name, bad, 0);
    endtask

    typedef struct {
        bit         is_wr;
        logic [1:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit         ok;
        int         s0;
        int         w0;
        int         scen;
        int         cnt;
        logic [7:0] v;
        logic [7:0] r;
        logic [7:0] exp_result;

        // op, addr, data (write) or expected readdata (read)
        vecs.push_back('{0, 2'd0, 8'h00});
        vecs.push_back('{0, 2'd2, 8'h00});
        vecs.push_back('{0, 2'd3, 8'h00});
        vecs.push_back('{1, 2'd0, 8'h01});
        vecs.push_back('{0, 2'd0, 8'h01});
        vecs.push_back('{1, 2'd1, 8'hAA});
        vecs.push_back('{1, 2'd1, 8'hBB});
        vecs.push_back('{0, 2'd3, 8'h02});
        vecs.push_back('{0, 2'd1, 8'h00});
        vecs.push_back('{1, 2'd0, 8'h03});
        vecs.push_back('{0, 2'd0, 8'h00});
        vecs.push_back('{0, 2'd3, 8'h00});
        vecs.push_back('{1, 2'd1, 8'h55});
        vecs.push_back('{0, 2'd0, 8'h08});
        vecs.push_back('{1, 2'd0, 8'h01});
        vecs.push_back('{0, 2'd0, 8'h01});
        vecs.push_back('{1, 2'd0, 8'h02});
        vecs.push_back('{0, 2'd0, 8'h00});

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset irq", irq, 0);
        chk("reset ram_we", ram_we, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset ram_wdata", ram_wdata, 0);
        chk("reset eng_start", eng_start, 0);
        chk("reset readdata", readdata, 0);

        // vector table: status/count reads, abort, illegal DATA write, err clear
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
            else rd_chk(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
        end
        chk("vec ram writes", we_cnt, 2);
        chk("vec mem0", mem[0], 8'hAA);
        chk("vec mem1", mem[1], 8'hBB);
        chk("vec no start", start_cnt, 0);

        // directed load of 0..95 then completion
        for (int i = 0; i < TOTAL; i++) exp_bytes[i] = 8'(i);
        w0 = we_cnt; s0 = start_cnt;
        full_load();
        chk("load we count", we_cnt - w0, TOTAL);
        check_mem(TOTAL, "load data");
        chk("last addr", ram_addr, TOTAL - 1);
        wait_start(s0, ok);
        chk("start seen", ok, 1);
        chk("start latency", start_cyc - last_we_cyc, 1);
        rd_chk(2'd0, 8'h02, "status run");
        pulse_done(8'hA7);
        rd_chk(2'd0, 8'h04, "status done");
        chk("irq done", irq, 1);
        rd_chk(2'd2, 8'hA7, "result");
        rd_chk(2'd0, 8'h00, "status after read");
        chk("irq cleared", irq, 0);
        chk("one start", start_cnt - s0, 1);

        // timeout exactly TO cycles after eng_start
        for (int i = 0; i < TOTAL; i++) exp_bytes[i] = 8'($urandom);
        s0 = start_cnt;
        full_load();
        wait_start(s0, ok);
        chk("to start seen", ok, 1);
        s0 = start_cyc;
        while (cyc < s0 + TO - 1) tick();
        rd_chk(2'd0, 8'h02, "before timeout");
        chk("irq before timeout", irq, 0);
        rd_chk(2'd0, 8'h08, "timeout status");
        chk("irq timeout", irq, 1);
        wr(2'd0, 8'h01);
        rd_chk(2'd0, 8'h01, "err cleared");
        wr(2'd0, 8'h02);

        // eng_done on the timeout cycle: completion wins
        s0 = start_cnt;
        full_load();
        wait_start(s0, ok);
        s0 = start_cyc;
        while (cyc < s0 + TO - 1) tick();
        pulse_done(8'h3C);
        rd_chk(2'd0, 8'h04, "done wins");
        rd_chk(2'd2, 8'h3C, "done wins result");
        pulse_done(8'hFF);
        rd_chk(2'd0, 8'h00, "idle done ignored");
        rd_chk(2'd2, 8'h3C, "idle result kept");

        // reset after the 50th DATA write
        wr(2'd0, 8'h01);
        w0 = we_cnt;
        for (int i = 0; i < 50; i++) wr(2'd1, 8'(i + 7));
        reset = 1'b1;
        tick();
        chk("rst ram_we", ram_we, 0);
        chk("rst outs", {readdata, ram_addr, ram_wdata, irq, eng_start}, 0);
        chk("rst we count", we_cnt - w0, 50);
        reset = 1'b0;
        rd_chk(2'd3, 8'h00, "rst count");
        rd_chk(2'd2, 8'h00, "rst result");
        for (int i = 0; i < TOTAL; i++) exp_bytes[i] = 8'($urandom);
        s0 = start_cnt;
        full_load();
        check_mem(TOTAL, "reload data");
        wait_start(s0, ok);
        chk("reload start", ok, 1);
        pulse_done(8'h5E);
        rd_chk(2'd2, 8'h5E, "reload result");
        exp_result = 8'h5E;

        // randomized scenarios against a byte-level model
        for (int it = 0; it < 12; it++) begin
            scen = int'($urandom_range(0, 3));
            s0 = start_cnt;
            wr(2'd0, 8'h01);
            cnt = 0;
            w0 = (scen == 2) ? int'($urandom_range(1, TOTAL - 1)) : TOTAL;
            while (cnt < w0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: begin
                        exp_bytes[cnt] = 8'($urandom);
                        wr(2'd1, exp_bytes[cnt]);
                        cnt++;
                    end
                    6: tick();
                    7: begin
                        rd_chk(2'd3, 8'(cnt), "rnd count");
                        rd_chk(2'd0, 8'h01, "rnd loading");
                    end
                    8: pulse_done(8'($urandom));
                    default: if ($urandom_range(0, 3) == 0) begin
                        wr(2'd0, 8'h01);
                        cnt = 0;
                    end
                endcase
            end
            check_mem(cnt, "rnd data");
            if (scen == 2) begin
                wr(2'd0, 8'h02);
                rd_chk(2'd3, 8'h00, "rnd abort count");
                rd_chk(2'd0, 8'h00, "rnd abort status");
                chk("rnd abort no start", start_cnt - s0, 0);
                continue;
            end
            wait_start(s0, ok);
            chk("rnd start", ok, 1);
            rd_chk(2'd0, 8'h02, "rnd running");
            if (scen == 0) begin
                repeat ($urandom_range(0, TO - 4)) tick();
                r = 8'($urandom);
                pulse_done(r);
                exp_result = r;
                rd_chk(2'd0, 8'h04, "rnd done");
                rd_chk(2'd2, exp_result, "rnd result");
                rd_chk(2'd0, 8'h00, "rnd after read");
            end else if (scen == 1) begin
                v = 8'h02;
                for (int k = 0; k < TO + 8; k++) begin
                    rd(2'd0, v);
                    if (v != 8'h02) break;
                end
                chk("rnd timeout", v, 8'h08);
            end else begin
                repeat ($urandom_range(0, 10)) tick();
                wr(2'd0, 8'h02);
                rd_chk(2'd0, 8'h00, "rnd run abort");
                rd_chk(2'd2, exp_result, "rnd result kept");
            end
            chk("rnd one start", start_cnt - s0, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
